// File: rtl/clk_sched_pkg.sv
// ---------------------------------------------------------------------------
// clk_sched_pkg
// Shared definitions for the clock-enable scheduler:
//   - state_t      : scheduler FSM state (IDLE, ARM, RUN), 2-bit encoding
//   - DEF_NUM_CH   : default number of strobe channels
//   - DEF_DIV_W    : default width of each channel's divide value
// ---------------------------------------------------------------------------
package clk_sched_pkg;

    localparam int DEF_NUM_CH = 4;
    localparam int DEF_DIV_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ARM  = 2'd1,
        RUN  = 2'd2
    } state_t;

endpackage : clk_sched_pkg

// File: rtl/clk_en_scheduler_if.sv
// ---------------------------------------------------------------------------
// clk_en_scheduler_if
// Control, configuration and strobe bundle of the clock-enable scheduler.
//   start, stop            : run / halt requests        (master -> slave)
//   cfg_valid, cfg_ch,
//   cfg_div                : divide-value write         (master -> slave)
//   cfg_ready              : write accepted (IDLE only) (slave -> master)
//   en_out[NUM_CH]         : one-cycle enable strobes   (slave -> master)
//   busy                   : scheduler not in IDLE      (slave -> master)
//   tick_cnt[7:0]          : en_out[0] strobe count, present only when the
//                            TICK_COUNT_EN macro is defined
// ---------------------------------------------------------------------------
interface clk_en_scheduler_if
    import clk_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
) ();

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic              start;
    logic              stop;
    logic              cfg_valid;
    logic              cfg_ready;
    logic [CH_W-1:0]   cfg_ch;
    logic [DIV_W-1:0]  cfg_div;
    logic [NUM_CH-1:0] en_out;
    logic              busy;
`ifdef TICK_COUNT_EN
    logic [7:0]        tick_cnt;

    modport master (
        output start, stop, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, en_out, busy, tick_cnt
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, en_out, busy, tick_cnt
    );
`else
    modport master (
        output start, stop, cfg_valid, cfg_ch, cfg_div,
        input  cfg_ready, en_out, busy
    );

    modport slave (
        input  start, stop, cfg_valid, cfg_ch, cfg_div,
        output cfg_ready, en_out, busy
    );
`endif

endinterface : clk_en_scheduler_if

// File: rtl/sched_channel.sv
// ---------------------------------------------------------------------------
// sched_channel
// One strobe channel: divide register, down-counter and strobe decode.
//   clk_in, rst : clock, asynchronous active-high reset
//   i_wr_en     : store i_wr_div into the divide register
//   i_wr_div    : divide value N (0 disables the channel)
//   i_arm       : scheduler in ARM -> preload counter with N-1
//   i_run       : scheduler in RUN -> count
//   i_gate      : strobe permission (RUN and no stop this cycle)
//   o_en        : combinational one-cycle strobe
// ---------------------------------------------------------------------------
module sched_channel #(
    parameter int DIV_W = 8
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             i_wr_en,
    input  logic [DIV_W-1:0] i_wr_div,
    input  logic             i_arm,
    input  logic             i_run,
    input  logic             i_gate,
    output logic             o_en
);

    localparam logic [DIV_W-1:0] ONE  = DIV_W'(1);
    localparam logic [DIV_W-1:0] ZERO = DIV_W'(0);

    logic [DIV_W-1:0] r_div;
    logic [DIV_W-1:0] r_cnt;
    logic [DIV_W-1:0] w_reload;
    logic             w_div_nz;

    // N-1 wraps for N=0; harmless because a zero divide never strobes or counts.
    assign w_reload = r_div - ONE;
    assign w_div_nz = (r_div != ZERO);

    // Divide register, written only when the top accepts a config write.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_div <= ZERO;
        end else if (i_wr_en) begin
            r_div <= i_wr_div;
        end else begin
            r_div <= r_div;
        end
    end

    // Down-counter: preload in ARM so every channel starts phase-aligned in RUN.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_cnt <= ZERO;
        end else if (i_arm) begin
            r_cnt <= w_reload;
        end else if (i_run && w_div_nz) begin
            if (r_cnt == ZERO) begin
                r_cnt <= w_reload;
            end else begin
                r_cnt <= r_cnt - ONE;
            end
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_en = i_gate & w_div_nz & (r_cnt == ZERO);

endmodule : sched_channel

// File: rtl/clk_en_scheduler.sv
// ---------------------------------------------------------------------------
// clk_en_scheduler
// Generates NUM_CH programmable clock-enable strobes. Divide values are
// written while IDLE; start arms all channels, which then strobe every N
// cycles in RUN, phase-aligned at RUN entry. stop returns to IDLE.
//   clk_in : clock (rising edge)
//   rst    : asynchronous active-high reset
//   bus    : clk_en_scheduler_if.slave (start/stop, cfg_*, en_out, busy,
//            tick_cnt when TICK_COUNT_EN is defined)
// Optional feature macro: TICK_COUNT_EN adds an 8-bit count of en_out[0]
// strobes, cleared on reset and on every ARM cycle.
// ---------------------------------------------------------------------------
module clk_en_scheduler
    import clk_sched_pkg::*;
#(
    parameter int NUM_CH = DEF_NUM_CH,
    parameter int DIV_W  = DEF_DIV_W
) (
    input  logic              clk_in,
    input  logic              rst,
    clk_en_scheduler_if.slave bus
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            r_state;
    state_t            w_next_state;
    logic              w_idle;
    logic              w_arm;
    logic              w_run;
    logic              w_gate;
    logic              w_cfg_wr;
    logic [NUM_CH-1:0] w_en;

    // State register.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; stop is only looked at outside IDLE, so it wins over start.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (bus.start) begin
                    w_next_state = ARM;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ARM: begin
                if (bus.stop) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RUN;
                end
            end
            RUN: begin
                if (bus.stop) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = RUN;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign w_idle   = (r_state == IDLE);
    assign w_arm    = (r_state == ARM);
    assign w_run    = (r_state == RUN);
    // Strobes are suppressed in the RUN cycle where stop is sampled.
    assign w_gate   = w_run & ~bus.stop;
    // Writes outside IDLE are dropped; out-of-range channels match no slice.
    assign w_cfg_wr = bus.cfg_valid & w_idle;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CH_W-1:0] CH_IDX = CH_W'(g);

        sched_channel #(
            .DIV_W (DIV_W)
        ) u_ch (
            .clk_in   (clk_in),
            .rst      (rst),
            .i_wr_en  (w_cfg_wr & (bus.cfg_ch == CH_IDX)),
            .i_wr_div (bus.cfg_div),
            .i_arm    (w_arm),
            .i_run    (w_run),
            .i_gate   (w_gate),
            .o_en     (w_en[g])
        );
    end

    assign bus.en_out    = w_en;
    assign bus.cfg_ready = w_idle;
    assign bus.busy      = ~w_idle;

`ifdef TICK_COUNT_EN
    logic [7:0] r_tick_cnt;

    // Strobe counter for channel 0, restarted on each ARM; wraps modulo 256.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            r_tick_cnt <= 8'd0;
        end else if (w_arm) begin
            r_tick_cnt <= 8'd0;
        end else if (w_en[0]) begin
            r_tick_cnt <= r_tick_cnt + 8'd1;
        end else begin
            r_tick_cnt <= r_tick_cnt;
        end
    end

    assign bus.tick_cnt = r_tick_cnt;
`endif

endmodule : clk_en_scheduler

// File: doc/clk_en_scheduler.md
CLK_EN_SCHEDULER -- requirements
Module: clk_en_scheduler

Interface
REQ-001 Parameter NUM_CH, default 4, SHALL set the number of strobe channels (2..8).
REQ-002 Parameter DIV_W, default 8, SHALL set the width of each channel's divide value.
REQ-003 clk_in  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-high.
REQ-005 start  input  1  SHALL be the run request, sampled in IDLE.
REQ-006 stop  input  1  SHALL be the halt request, sampled in ARM/RUN.
REQ-007 cfg_valid  input  1  SHALL qualify a divide-value write.
REQ-008 cfg_ready  output  1  SHALL be high exactly when state is IDLE.
REQ-009 cfg_ch  input  $clog2(NUM_CH)  SHALL select the target channel.
REQ-010 cfg_div  input  DIV_W  SHALL be the divide value to store.
REQ-011 en_out  output  NUM_CH  SHALL carry one-cycle enable strobes, one bit per channel.
REQ-012 busy  output  1  SHALL be high whenever state is not IDLE.

Function
REQ-013 FSM SHALL have states IDLE, ARM, RUN, encoded in 2 bits.
REQ-014 IDLE->ARM on start=1; ARM->RUN unconditionally; ARM/RUN->IDLE on stop=1; stop SHALL override start.
REQ-015 Write SHALL occur on the edge where cfg_valid & cfg_ready: div[cfg_ch] <= cfg_div.
REQ-016 cfg_valid in ARM/RUN SHALL be ignored (no write, no queuing).
REQ-017 A write with cfg_ch >= NUM_CH SHALL be accepted and discarded.
REQ-018 On the ARM cycle each channel counter SHALL load div[i]-1, truncated to DIV_W bits.
REQ-019 In RUN, counter i SHALL reload div[i]-1 when zero and otherwise decrement.
REQ-020 en_out[i] SHALL be combinational: (state==RUN) & (div[i]!=0) & (cnt[i]==0).
REQ-021 Divide value N>=1 SHALL give one strobe every N cycles; first strobe on the Nth RUN cycle.
REQ-022 N=0 SHALL disable the channel: en_out[i] held 0 and counter frozen.
REQ-023 N=1 SHALL hold en_out[i] high on every RUN cycle.
REQ-024 All channels SHALL be phase-aligned at RUN entry; channels with equal N strobe together.
REQ-025 en_out SHALL be all-zero outside RUN, including the cycle stop is sampled.
REQ-026 Latency: start sampled at edge k, ARM in cycle k+1, RUN from cycle k+2.

Reset
REQ-027 rst=1 SHALL force IDLE, all div[i]=0, all cnt[i]=0, en_out=0, busy=0, and cfg_ready=1 once rst=0.
REQ-028 rst asserted mid-RUN SHALL drop en_out immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro TICK_COUNT_EN, when defined, SHALL add output tick_cnt[7:0]: it clears on rst and on ARM, and increments (mod 256) on each en_out[0] strobe.
REQ-030 Without TICK_COUNT_EN, port tick_cnt and its logic SHALL be absent; all other behaviour is identical.

Structure
REQ-031 Shared package clk_sched_pkg SHALL hold the state enum (IDLE, ARM, RUN) and the NUM_CH/DIV_W defaults.
REQ-032 Sub-module sched_channel (divide register, down-counter, strobe decode) SHALL be instantiated NUM_CH times.

Verification
REQ-033 div0=4, div1=2 written in IDLE, then start -> en_out[0] on RUN cycles 3,7,11 (0-indexed); en_out[1] on cycles 1,3,5.
REQ-034 div2=0, div3=1, then start -> en_out[2] never high; en_out[3] high on every RUN cycle.
REQ-035 cfg_valid with cfg_div=9 during RUN; later stop and read back via strobe period -> old value retained, cfg_ready=0 throughout RUN.
REQ-036 start and stop high in the same cycle while in RUN -> IDLE next cycle, en_out=0, busy=0.
REQ-037 rst pulsed mid-RUN with div0=3 -> en_out=0 and busy=0 immediately; a restart with no rewrite produces no strobes (div cleared).
REQ-038 TICK_COUNT_EN defined, div0=1, 300 RUN cycles -> tick_cnt=44 (300 mod 256).
